// File: rtl/serial_num_loader_if.sv
// Bundle between a serial frame source and serial_num_loader.
// Source drives start/sdata; the loader drives number/valid/busy/err.
interface serial_num_loader_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sdata;
  logic [WIDTH-1:0] number;
  logic             valid;
  logic             busy;
  logic             err;

  modport master (
    output start, sdata,
    input  number, valid, busy, err
  );

  modport slave (
    input  start, sdata,
    output number, valid, busy, err
  );
endinterface

// File: rtl/serial_num_loader.sv
// Serial-to-parallel loader: start strobe, WIDTH data bits, parallel result.
// Optional even-parity bit after the data when PARITY_CHECK_EN is defined.
module serial_num_loader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_num_loader_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_number;
  logic             r_valid;
  logic             r_busy;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_last;

  // Shift register contents once the current sdata bit is folded in
  always_comb begin
    w_shift_nxt = r_shift;
    if (MSB_FIRST)
      w_shift_nxt = {r_shift[WIDTH-2:0], bus.sdata};
    else
      w_shift_nxt = {bus.sdata, r_shift[WIDTH-1:1]};
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef PARITY_CHECK_EN
  logic r_err;
  logic w_par_ok;

  assign w_par_ok = ~(^{r_shift, bus.sdata});
  assign bus.err  = r_err;
`else
  assign bus.err  = 1'b0;
`endif

  // Frame FSM: number only moves on a completed, good frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_number <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
`ifdef PARITY_CHECK_EN
            r_state  <= S_PARITY;
`else
            r_state  <= S_IDLE;
            r_number <= w_shift_nxt;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        S_PARITY: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (w_par_ok) begin
            r_number <= r_shift;
            r_valid  <= 1'b1;
          end else begin
            r_err    <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.number = r_number;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;

endmodule
